// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared state, field encodings and BCD limits for time setting
package clock_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    EDIT_H = 2'd1,
    EDIT_M = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam logic [1:0] FIELD_NONE    = 2'b00;
  localparam logic [1:0] FIELD_HOURS   = 2'b01;
  localparam logic [1:0] FIELD_MINUTES = 2'b10;

  localparam logic [7:0] BCD_ZERO  = 8'h00;
  localparam logic [7:0] HR24_MAX  = 8'h23;
  localparam logic [7:0] HR12_MIN  = 8'h01;
  localparam logic [7:0] HR12_MAX  = 8'h12;
  localparam logic [7:0] HR12_NOON_PREV = 8'h11;
  localparam logic [7:0] MIN_MAX   = 8'h59;

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Packed BCD compares are monotonic once both digits are known valid.
  function automatic logic [7:0] sanitize_hour(input logic [7:0] h, input logic fmt12);
    if (fmt12)
      return (bcd_ok(h) && h >= HR12_MIN && h <= HR12_MAX) ? h : HR12_MAX;
    return (bcd_ok(h) && h <= HR24_MAX) ? h : BCD_ZERO;
  endfunction

  function automatic logic [7:0] sanitize_minute(input logic [7:0] m);
    return (bcd_ok(m) && m <= MIN_MAX) ? m : BCD_ZERO;
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// rtl/time_set_ctrl_if.sv - button, live-time and shadow/set signals of the time-set controller
interface time_set_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_dec;
  logic       btn_fmt;
  logic [3:0] cur_h1, cur_h0, cur_m1, cur_m0;
  logic       cur_am_pm;
  logic       set;
  logic [3:0] set_h1, set_h0, set_m1, set_m0;
  logic       set_am_pm;
  logic       mode_12h;
  logic [1:0] edit_field;
  logic       blink;

  modport master (
    output btn_mode, btn_inc, btn_dec, btn_fmt,
    output cur_h1, cur_h0, cur_m1, cur_m0, cur_am_pm,
    input  set, set_h1, set_h0, set_m1, set_m0, set_am_pm,
    input  mode_12h, edit_field, blink
  );

  modport slave (
    input  btn_mode, btn_inc, btn_dec, btn_fmt,
    input  cur_h1, cur_h0, cur_m1, cur_m0, cur_am_pm,
    output set, set_h1, set_h0, set_m1, set_m0, set_am_pm,
    output mode_12h, edit_field, blink
  );
endinterface

// File: rtl/bcd_step.sv
// rtl/bcd_step.sv - combinational 2-digit BCD increment/decrement with lo/hi wrap
module bcd_step (
  input  logic [7:0] val,
  input  logic       inc,
  input  logic       dec,
  input  logic [7:0] lo,
  input  logic [7:0] hi,
  output logic [7:0] nxt,
  output logic       wrap
);
  always_comb begin
    nxt  = val;
    wrap = 1'b0;
    if (inc && !dec) begin
      if (val >= hi) begin
        nxt  = lo;
        wrap = 1'b1;
      end else if (val[3:0] == 4'd9) begin
        nxt = {val[7:4] + 4'd1, 4'd0};
      end else begin
        nxt = {val[7:4], val[3:0] + 4'd1};
      end
    end else if (dec && !inc) begin
      if (val <= lo) begin
        nxt  = hi;
        wrap = 1'b1;
      end else if (val[3:0] == 4'd0) begin
        nxt = {val[7:4] - 4'd1, 4'd9};
      end else begin
        nxt = {val[7:4], val[3:0] - 4'd1};
      end
    end
  end
endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - capture/edit/commit sequencer for the clock's hour and minute counters
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned SET_HOLD  = 4,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned BLINK_DIV = 64
) (
  input logic           clk,
  input logic           rst,
  time_set_ctrl_if.slave bus
);
  localparam int HW = $clog2(SET_HOLD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(SET_HOLD - 1);
  localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] idle_cnt;
  logic [BW-1:0] blink_cnt;
  logic [7:0]    sh_h, sh_m, h_nxt, m_nxt, h_lo, h_hi;
  logic          am_pm, set_q, mode_12h_q, blink_q;
  logic [1:0]    field_q;
  logic          step_inc, step_dec, any_btn, ampm_flip;
  logic          h_wrap_unused, m_wrap_unused;

  // Mode wins over a step; inc together with dec cancels out.
  assign step_inc  = bus.btn_inc & ~bus.btn_dec & ~bus.btn_mode;
  assign step_dec  = bus.btn_dec & ~bus.btn_inc & ~bus.btn_mode;
  assign any_btn   = bus.btn_mode | bus.btn_inc | bus.btn_dec | bus.btn_fmt;
  assign h_lo      = mode_12h_q ? HR12_MIN : BCD_ZERO;
  assign h_hi      = mode_12h_q ? HR12_MAX : HR24_MAX;
  assign ampm_flip = mode_12h_q & ((step_inc & (sh_h == HR12_NOON_PREV)) |
                                   (step_dec & (sh_h == HR12_MAX)));

  bcd_step u_hour (.val(sh_h), .inc(step_inc), .dec(step_dec), .lo(h_lo), .hi(h_hi),
                   .nxt(h_nxt), .wrap(h_wrap_unused));
  bcd_step u_min  (.val(sh_m), .inc(step_inc), .dec(step_dec), .lo(BCD_ZERO), .hi(MIN_MAX),
                   .nxt(m_nxt), .wrap(m_wrap_unused));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      set_q      <= 1'b0;
      sh_h       <= BCD_ZERO;
      sh_m       <= BCD_ZERO;
      am_pm      <= 1'b0;
      mode_12h_q <= 1'b0;
      field_q    <= FIELD_NONE;
      blink_q    <= 1'b0;
      hold_cnt   <= '0;
      idle_cnt   <= '0;
      blink_cnt  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (bus.btn_fmt) mode_12h_q <= ~mode_12h_q;
          if (bus.btn_mode) begin
            state     <= EDIT_H;
            sh_h      <= sanitize_hour({bus.cur_h1, bus.cur_h0}, mode_12h_q);
            sh_m      <= sanitize_minute({bus.cur_m1, bus.cur_m0});
            am_pm     <= bus.cur_am_pm;
            field_q   <= FIELD_HOURS;
            blink_q   <= 1'b1;
            blink_cnt <= '0;
            idle_cnt  <= '0;
          end
        end
        EDIT_H, EDIT_M: begin
          if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_q   <= ~blink_q;
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
          end
          if (any_btn) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            // Abandoned edit: drop the shadow, never touch the counters.
            state   <= RUN;
            sh_h    <= BCD_ZERO;
            sh_m    <= BCD_ZERO;
            am_pm   <= 1'b0;
            field_q <= FIELD_NONE;
            blink_q <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
          if (bus.btn_mode) begin
            if (state == EDIT_H) begin
              state     <= EDIT_M;
              field_q   <= FIELD_MINUTES;
              blink_q   <= 1'b1;
              blink_cnt <= '0;
            end else begin
              state    <= COMMIT;
              set_q    <= 1'b1;
              hold_cnt <= '0;
              field_q  <= FIELD_NONE;
              blink_q  <= 1'b0;
            end
          end else if (state == EDIT_H) begin
            sh_h <= h_nxt;
            if (ampm_flip) am_pm <= ~am_pm;
          end else begin
            sh_m <= m_nxt;
          end
        end
        COMMIT: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= RUN;
            set_q <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.set        = set_q;
  assign bus.set_h1     = sh_h[7:4];
  assign bus.set_h0     = sh_h[3:0];
  assign bus.set_m1     = sh_m[7:4];
  assign bus.set_m0     = sh_m[3:0];
  assign bus.set_am_pm  = am_pm;
  assign bus.mode_12h   = mode_12h_q;
  assign bus.edit_field = field_q;
  assign bus.blink      = blink_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - directed-vector bench for the time-set controller
module tb_time_set_ctrl;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   set_cnt;

  time_set_ctrl_if bus();

  time_set_ctrl #(.SET_HOLD(4), .TIMEOUT(1024), .BLINK_DIV(64)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.set === 1'b1) set_cnt++;

  function automatic logic [7:0] sh_h();
    return {bus.set_h1, bus.set_h0};
  endfunction

  function automatic logic [7:0] sh_m();
    return {bus.set_m1, bus.set_m0};
  endfunction

  task automatic set_cur(input logic [7:0] h, input logic [7:0] m, input logic ap);
    bus.cur_h1 = h[7:4]; bus.cur_h0 = h[3:0];
    bus.cur_m1 = m[7:4]; bus.cur_m0 = m[3:0];
    bus.cur_am_pm = ap;
  endtask

  task automatic press(input logic m, input logic i, input logic d, input logic f);
    @(negedge clk);
    bus.btn_mode = m; bus.btn_inc = i; bus.btn_dec = d; bus.btn_fmt = f;
    @(negedge clk);
    bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.btn_dec = 1'b0; bus.btn_fmt = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors += 7;
    if (bus.set !== 1'b0) begin miscompares++; $display("FAIL rst_set got %b want 0", bus.set); end
    if (sh_h() !== 8'h00) begin miscompares++; $display("FAIL rst_hour got %h want 00", sh_h()); end
    if (sh_m() !== 8'h00) begin miscompares++; $display("FAIL rst_min got %h want 00", sh_m()); end
    if (bus.set_am_pm !== 1'b0) begin miscompares++; $display("FAIL rst_ampm got %b want 0", bus.set_am_pm); end
    if (bus.mode_12h !== 1'b0) begin miscompares++; $display("FAIL rst_fmt got %b want 0", bus.mode_12h); end
    if (bus.edit_field !== 2'b00) begin miscompares++; $display("FAIL rst_field got %b want 00", bus.edit_field); end
    if (bus.blink !== 1'b0) begin miscompares++; $display("FAIL rst_blink got %b want 0", bus.blink); end
    rst = 1'b0;
  endtask

  task automatic test_fmt();
    int base = set_cnt;
    press(0, 0, 0, 1);
    vectors++;
    if (bus.mode_12h !== 1'b1) begin miscompares++; $display("FAIL fmt_on got %b want 1", bus.mode_12h); end
    press(0, 1, 1, 0);
    press(0, 0, 0, 1);
    vectors += 2;
    if (bus.mode_12h !== 1'b0) begin miscompares++; $display("FAIL fmt_off got %b want 0", bus.mode_12h); end
    if (set_cnt !== base) begin miscompares++; $display("FAIL fmt_noset got %0d want %0d", set_cnt, base); end
  endtask

  task automatic test_edit_24h();
    int base;
    set_cur(8'h23, 8'h58, 1'b0);
    press(1, 0, 0, 0);
    vectors += 4;
    if (bus.edit_field !== 2'b01) begin miscompares++; $display("FAIL e24_field_h got %b want 01", bus.edit_field); end
    if (sh_h() !== 8'h23) begin miscompares++; $display("FAIL e24_cap_h got %h want 23", sh_h()); end
    if (sh_m() !== 8'h58) begin miscompares++; $display("FAIL e24_cap_m got %h want 58", sh_m()); end
    if (bus.blink !== 1'b1) begin miscompares++; $display("FAIL e24_blink got %b want 1", bus.blink); end
    press(0, 1, 0, 0);
    vectors += 2;
    if (sh_h() !== 8'h00) begin miscompares++; $display("FAIL e24_inc_wrap got %h want 00", sh_h()); end
    if (bus.set_am_pm !== 1'b0) begin miscompares++; $display("FAIL e24_ampm got %b want 0", bus.set_am_pm); end
    press(0, 0, 1, 0);
    vectors++;
    if (sh_h() !== 8'h23) begin miscompares++; $display("FAIL e24_dec_wrap got %h want 23", sh_h()); end
    press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    vectors++;
    if (bus.edit_field !== 2'b10) begin miscompares++; $display("FAIL e24_field_m got %b want 10", bus.edit_field); end
    press(0, 1, 0, 0);
    vectors++;
    if (sh_m() !== 8'h59) begin miscompares++; $display("FAIL e24_min59 got %h want 59", sh_m()); end
    press(0, 1, 0, 0);
    vectors += 2;
    if (sh_m() !== 8'h00) begin miscompares++; $display("FAIL e24_min_wrap got %h want 00", sh_m()); end
    if (sh_h() !== 8'h00) begin miscompares++; $display("FAIL e24_no_carry got %h want 00", sh_h()); end
    base = set_cnt;
    press(1, 0, 0, 0);
    vectors += 4;
    if (bus.set !== 1'b1) begin miscompares++; $display("FAIL e24_set_on got %b want 1", bus.set); end
    if (sh_h() !== 8'h00 || sh_m() !== 8'h00) begin miscompares++; $display("FAIL e24_commit_val got %h:%h want 00:00", sh_h(), sh_m()); end
    if (bus.edit_field !== 2'b00) begin miscompares++; $display("FAIL e24_commit_field got %b want 00", bus.edit_field); end
    press(1, 1, 0, 1);
    if (bus.mode_12h !== 1'b0) begin miscompares++; $display("FAIL e24_commit_ign got %b want 0", bus.mode_12h); end
    repeat (6) @(negedge clk);
    vectors += 2;
    if (set_cnt - base !== 4) begin miscompares++; $display("FAIL e24_set_len got %0d want 4", set_cnt - base); end
    if (bus.set !== 1'b0) begin miscompares++; $display("FAIL e24_set_off got %b want 0", bus.set); end
  endtask

  task automatic test_edit_12h();
    press(0, 0, 0, 1);
    set_cur(8'h11, 8'h30, 1'b0);
    press(1, 0, 0, 0);
    vectors++;
    if (sh_h() !== 8'h11) begin miscompares++; $display("FAIL e12_cap got %h want 11", sh_h()); end
    press(0, 1, 0, 0);
    vectors += 2;
    if (sh_h() !== 8'h12) begin miscompares++; $display("FAIL e12_inc12 got %h want 12", sh_h()); end
    if (bus.set_am_pm !== 1'b1) begin miscompares++; $display("FAIL e12_pm got %b want 1", bus.set_am_pm); end
    press(0, 1, 0, 0);
    vectors += 2;
    if (sh_h() !== 8'h01) begin miscompares++; $display("FAIL e12_inc01 got %h want 01", sh_h()); end
    if (bus.set_am_pm !== 1'b1) begin miscompares++; $display("FAIL e12_pm_keep got %b want 1", bus.set_am_pm); end
    press(0, 0, 1, 0);
    vectors += 2;
    if (sh_h() !== 8'h12) begin miscompares++; $display("FAIL e12_dec12 got %h want 12", sh_h()); end
    if (bus.set_am_pm !== 1'b1) begin miscompares++; $display("FAIL e12_pm_keep2 got %b want 1", bus.set_am_pm); end
    press(0, 0, 1, 0);
    vectors += 2;
    if (sh_h() !== 8'h11) begin miscompares++; $display("FAIL e12_dec11 got %h want 11", sh_h()); end
    if (bus.set_am_pm !== 1'b0) begin miscompares++; $display("FAIL e12_am got %b want 0", bus.set_am_pm); end
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    repeat (6) @(negedge clk);
    set_cur(8'h13, 8'h05, 1'b1);
    press(1, 0, 0, 0);
    vectors += 2;
    if (sh_h() !== 8'h12) begin miscompares++; $display("FAIL e12_sanitize got %h want 12", sh_h()); end
    if (bus.set_am_pm !== 1'b1) begin miscompares++; $display("FAIL e12_cap_pm got %b want 1", bus.set_am_pm); end
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    repeat (6) @(negedge clk);
    press(0, 0, 0, 1);
    vectors++;
    if (bus.mode_12h !== 1'b0) begin miscompares++; $display("FAIL e12_back24 got %b want 0", bus.mode_12h); end
  endtask

  task automatic test_timeout();
    int base = set_cnt;
    set_cur(8'h07, 8'h15, 1'b0);
    press(1, 0, 0, 0);
    repeat (63) @(negedge clk);
    vectors++;
    if (bus.blink !== 1'b1) begin miscompares++; $display("FAIL to_blink_hi got %b want 1", bus.blink); end
    @(negedge clk);
    vectors++;
    if (bus.blink !== 1'b0) begin miscompares++; $display("FAIL to_blink_lo got %b want 0", bus.blink); end
    repeat (959) @(negedge clk);
    vectors++;
    if (bus.edit_field !== 2'b01) begin miscompares++; $display("FAIL to_early got %b want 01", bus.edit_field); end
    @(negedge clk);
    vectors += 3;
    if (bus.edit_field !== 2'b00) begin miscompares++; $display("FAIL to_abort got %b want 00", bus.edit_field); end
    if (bus.blink !== 1'b0) begin miscompares++; $display("FAIL to_blink_off got %b want 0", bus.blink); end
    if (set_cnt !== base) begin miscompares++; $display("FAIL to_noset got %0d want %0d", set_cnt, base); end
    set_cur(8'h09, 8'h41, 1'b0);
    press(1, 0, 0, 0);
    vectors++;
    if (sh_h() !== 8'h09 || sh_m() !== 8'h41) begin miscompares++; $display("FAIL to_recap got %h:%h want 09:41", sh_h(), sh_m()); end
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    repeat (6) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    set_cur(8'h10, 8'h20, 1'b0);
    press(1, 0, 0, 0);
    press(0, 0, 0, 1);
    vectors += 2;
    if (bus.mode_12h !== 1'b0) begin miscompares++; $display("FAIL sim_fmt got %b want 0", bus.mode_12h); end
    if (bus.edit_field !== 2'b01) begin miscompares++; $display("FAIL sim_fmt_field got %b want 01", bus.edit_field); end
    press(1, 1, 0, 0);
    vectors += 2;
    if (bus.edit_field !== 2'b10) begin miscompares++; $display("FAIL sim_mode_wins got %b want 10", bus.edit_field); end
    if (sh_h() !== 8'h10) begin miscompares++; $display("FAIL sim_hour_kept got %h want 10", sh_h()); end
    press(0, 1, 1, 0);
    vectors++;
    if (sh_m() !== 8'h20) begin miscompares++; $display("FAIL sim_incdec got %h want 20", sh_m()); end
    press(0, 0, 1, 0);
    vectors++;
    if (sh_m() !== 8'h19) begin miscompares++; $display("FAIL sim_dec_borrow got %h want 19", sh_m()); end
    press(1, 0, 0, 0);
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_commit();
    set_cur(8'h05, 8'h06, 1'b1);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    vectors++;
    if (bus.set !== 1'b1) begin miscompares++; $display("FAIL rc_set_c1 got %b want 1", bus.set); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors += 3;
    if (bus.set !== 1'b0) begin miscompares++; $display("FAIL rc_set_drop got %b want 0", bus.set); end
    if (sh_h() !== 8'h00 || sh_m() !== 8'h00) begin miscompares++; $display("FAIL rc_shadow got %h:%h want 00:00", sh_h(), sh_m()); end
    if (bus.set_am_pm !== 1'b0) begin miscompares++; $display("FAIL rc_ampm got %b want 0", bus.set_am_pm); end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    vectors++;
    if (bus.set !== 1'b0) begin miscompares++; $display("FAIL rc_no_extend got %b want 0", bus.set); end
    set_cur(8'h25, 8'h61, 1'b0);
    press(1, 0, 0, 0);
    vectors += 2;
    if (bus.edit_field !== 2'b01) begin miscompares++; $display("FAIL rc_from_run got %b want 01", bus.edit_field); end
    if (sh_h() !== 8'h00 || sh_m() !== 8'h00) begin miscompares++; $display("FAIL rc_sanitize got %h:%h want 00:00", sh_h(), sh_m()); end
    set_cur(8'h1A, 8'h3F, 1'b0);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    repeat (6) @(negedge clk);
    press(1, 0, 0, 0);
    vectors++;
    if (sh_h() !== 8'h00 || sh_m() !== 8'h00) begin miscompares++; $display("FAIL rc_bad_digit got %h:%h want 00:00", sh_h(), sh_m()); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.btn_dec = 1'b0; bus.btn_fmt = 1'b0;
    set_cur(8'h12, 8'h34, 1'b1);
    test_reset();
    test_fmt();
    test_edit_24h();
    test_edit_12h();
    test_timeout();
    test_simultaneous();
    test_reset_commit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial set_cnt = 0;
endmodule
